rtc_snapshot_bank: RTL

//  Parametrised, qualified snapshot register bank between the PicoBlaze port

---
 rtl/rtc_snapshot_bank_if.sv | 42 ++++
 rtl/rtc_snapshot_bank.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/rtc_snapshot_bank_if.sv
// rtc_snapshot_bank_if
// Purpose: bundles the processor-side request signals and the display-side
// snapshot signals of the RTC snapshot bank into one interface.
// Signals:
//   hs_code     handshake code from the processor port
//   fields_in   packed live fields, field i at [i*FIELD_W +: FIELD_W]
//   snap_ack    consumer acknowledges the current snapshot
//   ovr_clr     clears the sticky overrun flag
//   fields_out  registered snapshot, same packing as fields_in
//   snap_valid  an unacknowledged snapshot is present
//   overrun     sticky: a capture overwrote an unacknowledged snapshot
//   locked      capture done, waiting for the code to be released
//   snap_count  captures since reset, wraps 255 -> 0
//   change_mask per-field changed flags of the latest capture
// Modports: master drives requests and observes the snapshot (processor and
// consumer side); slave is the snapshot bank itself.
interface rtc_snapshot_bank_if #(
    parameter int NUM_FIELDS = 16,
    parameter int FIELD_W    = 8,
    parameter int HS_W       = 8
);
    logic [HS_W-1:0]               hs_code;
    logic [NUM_FIELDS*FIELD_W-1:0] fields_in;
    logic                          snap_ack;
    logic                          ovr_clr;
    logic [NUM_FIELDS*FIELD_W-1:0] fields_out;
    logic                          snap_valid;
    logic                          overrun;
    logic                          locked;
    logic [7:0]                    snap_count;
    logic [NUM_FIELDS-1:0]         change_mask;

    modport master (
        output hs_code, fields_in, snap_ack, ovr_clr,
        input  fields_out, snap_valid, overrun, locked, snap_count, change_mask
    );

    modport slave (
        input  hs_code, fields_in, snap_ack, ovr_clr,
        output fields_out, snap_valid, overrun, locked, snap_count, change_mask
    );
endinterface

// File: rtl/rtc_snapshot_bank.sv
// rtc_snapshot_bank
// Purpose: qualified, atomic snapshot of NUM_FIELDS packed RTC/display fields.
// A capture happens only once the handshake code has matched HS_CODE for
// STABLE_CYCLES consecutive cycles, and only once per code assertion; the
// code has to be released before another capture can be qualified.
// Ports:
//   clock  system clock, rising edge
//   reset  asynchronous, active-high; returns every output to 0
//   bus    rtc_snapshot_bank_if.slave (hs_code, fields_in, snap_ack, ovr_clr
//          in; fields_out, snap_valid, overrun, locked, snap_count,
//          change_mask out). All outputs come straight from registers.
// Optional feature: define RTC_SNAPSHOT_CHANGE_MASK_EN to build the per-field
// change comparators; without it change_mask is tied to 0.
module rtc_snapshot_bank #(
    parameter int              NUM_FIELDS    = 16,
    parameter int              FIELD_W       = 8,
    parameter int              HS_W          = 8,
    parameter logic [HS_W-1:0] HS_CODE       = 8'hFF,
    parameter int              STABLE_CYCLES = 2
) (
    input logic                clock,
    input logic                reset,
    rtc_snapshot_bank_if.slave bus
);

    localparam int         TOTAL_W      = NUM_FIELDS * FIELD_W;
    localparam logic [3:0] STABLE_LIMIT = 4'(STABLE_CYCLES);

    typedef enum logic [1:0] {IDLE, QUAL, LOCKED} state_t;

    state_t             state_q;
    logic [3:0]         qualCnt_q;
    logic               locked_q;
    logic [TOTAL_W-1:0] fieldsOut_q;
    logic               snapValid_q;
    logic               overrun_q;
    logic [7:0]         snapCount_q;

    logic codeMatch;
    logic captureNow;
    logic overrunSet;

    // Decide whether this edge is the capture edge: the edge on which the
    // run of matching codes reaches STABLE_CYCLES. An overrun is only raised
    // when the capture replaces a snapshot the consumer has not acknowledged
    // on this same edge.
    always_comb begin
        codeMatch  = (bus.hs_code == HS_CODE);
        captureNow = 1'b0;
        case (state_q)
            IDLE:    captureNow = codeMatch && (STABLE_LIMIT == 4'd1);
            QUAL:    captureNow = codeMatch && ((qualCnt_q + 4'd1) == STABLE_LIMIT);
            default: captureNow = 1'b0;
        endcase
        overrunSet = captureNow && snapValid_q && !bus.snap_ack;
    end

    // Qualification FSM. LOCKED holds off re-capture until the code drops,
    // so a long-held code produces exactly one snapshot. locked_q mirrors the
    // LOCKED state as its own register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            qualCnt_q <= 4'd0;
            locked_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (codeMatch) begin
                        qualCnt_q <= 4'd1;
                        if (STABLE_LIMIT == 4'd1) begin
                            state_q  <= LOCKED;
                            locked_q <= 1'b1;
                        end else begin
                            state_q <= QUAL;
                        end
                    end
                end
                QUAL: begin
                    if (codeMatch) begin
                        qualCnt_q <= qualCnt_q + 4'd1;
                        if ((qualCnt_q + 4'd1) == STABLE_LIMIT) begin
                            state_q  <= LOCKED;
                            locked_q <= 1'b1;
                        end
                    end else begin
                        qualCnt_q <= 4'd0;
                        state_q   <= IDLE;
                    end
                end
                LOCKED: begin
                    if (!codeMatch) begin
                        qualCnt_q <= 4'd0;
                        state_q   <= IDLE;
                        locked_q  <= 1'b0;
                    end
                end
                default: begin
                    qualCnt_q <= 4'd0;
                    state_q   <= IDLE;
                    locked_q  <= 1'b0;
                end
            endcase
        end
    end

    // Snapshot datapath. A capture always wins over an acknowledge on the
    // same edge: the ack is taken as consuming the old snapshot, so the new
    // one stays valid. The set of overrun has priority over ovr_clr.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fieldsOut_q <= '0;
            snapValid_q <= 1'b0;
            overrun_q   <= 1'b0;
            snapCount_q <= 8'd0;
        end else begin
            if (captureNow) begin
                fieldsOut_q <= bus.fields_in;
                snapValid_q <= 1'b1;
                snapCount_q <= snapCount_q + 8'd1;
            end else if (bus.snap_ack) begin
                snapValid_q <= 1'b0;
            end
            if (overrunSet) begin
                overrun_q <= 1'b1;
            end else if (bus.ovr_clr) begin
                overrun_q <= 1'b0;
            end
        end
    end

`ifdef RTC_SNAPSHOT_CHANGE_MASK_EN
    logic [NUM_FIELDS-1:0] changeMask_q;

    // Per-field change flags, compared against the snapshot that is about to
    // be replaced (all zeros straight after reset), held until next capture.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            changeMask_q <= '0;
        end else if (captureNow) begin
            for (int i = 0; i < NUM_FIELDS; i++) begin
                changeMask_q[i] <= (bus.fields_in[i*FIELD_W +: FIELD_W] !=
                                    fieldsOut_q[i*FIELD_W +: FIELD_W]);
            end
        end
    end

    assign bus.change_mask = changeMask_q;
`else
    assign bus.change_mask = '0;
`endif

    assign bus.fields_out = fieldsOut_q;
    assign bus.snap_valid = snapValid_q;
    assign bus.overrun    = overrun_q;
    assign bus.locked     = locked_q;
    assign bus.snap_count = snapCount_q;

endmodule
